// File: rtl/debounce_fsm.sv
// Button debouncer: 2-flop synchronizer feeding a tick-qualified 4-state FSM.
// A new level is accepted after N_STABLE consecutive agreeing sample ticks.
module debounce_fsm #(
   parameter int N_STABLE = 4
) (
   input  logic clk,
   input  logic rst_a_n,
   input  logic btn_in,
   input  logic sample_tick,
   output logic btn_db,
   output logic btn_rise,
   output logic btn_fall,
   output logic busy
);

   localparam int CW = $clog2(N_STABLE + 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(N_STABLE);

   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } state_e;

   logic          btn_meta_q;
   logic          btn_sync_q;
   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_inc;
   logic          btn_db_q;
   logic          btn_rise_q;
   logic          btn_fall_q;
   logic          busy_q;

   // cnt_q stays below N_STABLE while waiting, so the increment always fits CW bits
   assign cnt_inc = cnt_q + CNT_ONE;

   // Two-flop synchronizer for the asynchronous button level
   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
      end else begin
         btn_meta_q <= btn_in;
         btn_sync_q <= btn_meta_q;
      end
   end

   // Qualification FSM with registered level, edge pulses and busy flag
   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         state_q    <= S_LOW;
         cnt_q      <= CNT_ZERO;
         btn_db_q   <= 1'b0;
         btn_rise_q <= 1'b0;
         btn_fall_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         btn_rise_q <= 1'b0;
         btn_fall_q <= 1'b0;
         if (sample_tick) begin
            case (state_q)
               S_LOW: begin
                  if (btn_sync_q) begin
                     if (N_STABLE == 1) begin
                        state_q    <= S_HIGH;
                        btn_db_q   <= 1'b1;
                        btn_rise_q <= 1'b1;
                        cnt_q      <= CNT_ZERO;
                        busy_q     <= 1'b0;
                     end else begin
                        state_q <= S_WAIT_HIGH;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                     end
                  end else begin
                     cnt_q  <= CNT_ZERO;
                     busy_q <= 1'b0;
                  end
               end
               S_WAIT_HIGH: begin
                  if (btn_sync_q) begin
                     if (cnt_inc == CNT_MAX) begin
                        state_q    <= S_HIGH;
                        btn_db_q   <= 1'b1;
                        btn_rise_q <= 1'b1;
                        cnt_q      <= CNT_ZERO;
                        busy_q     <= 1'b0;
                     end else begin
                        cnt_q  <= cnt_inc;
                        busy_q <= 1'b1;
                     end
                  end else begin
                     state_q <= S_LOW;
                     cnt_q   <= CNT_ZERO;
                     busy_q  <= 1'b0;
                  end
               end
               S_HIGH: begin
                  if (!btn_sync_q) begin
                     if (N_STABLE == 1) begin
                        state_q    <= S_LOW;
                        btn_db_q   <= 1'b0;
                        btn_fall_q <= 1'b1;
                        cnt_q      <= CNT_ZERO;
                        busy_q     <= 1'b0;
                     end else begin
                        state_q <= S_WAIT_LOW;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                     end
                  end else begin
                     cnt_q  <= CNT_ZERO;
                     busy_q <= 1'b0;
                  end
               end
               S_WAIT_LOW: begin
                  if (!btn_sync_q) begin
                     if (cnt_inc == CNT_MAX) begin
                        state_q    <= S_LOW;
                        btn_db_q   <= 1'b0;
                        btn_fall_q <= 1'b1;
                        cnt_q      <= CNT_ZERO;
                        busy_q     <= 1'b0;
                     end else begin
                        cnt_q  <= cnt_inc;
                        busy_q <= 1'b1;
                     end
                  end else begin
                     state_q <= S_HIGH;
                     cnt_q   <= CNT_ZERO;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q  <= S_LOW;
                  cnt_q    <= CNT_ZERO;
                  btn_db_q <= 1'b0;
                  busy_q   <= 1'b0;
               end
            endcase
         end else begin
            state_q  <= state_q;
            cnt_q    <= cnt_q;
            btn_db_q <= btn_db_q;
            busy_q   <= busy_q;
         end
      end
   end

   assign btn_db   = btn_db_q;
   assign btn_rise = btn_rise_q;
   assign btn_fall = btn_fall_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm: N_STABLE=4 and N_STABLE=1 instances share stimulus.
module tb_debounce_fsm;

   logic clk = 1'b0;
   logic rst_a_n, btn_in, sample_tick;
   logic db_a, rise_a, fall_a, busy_a;
   logic db_b, rise_b, fall_b, busy_b;

   always #5 clk = ~clk;

   debounce_fsm #(.N_STABLE(4)) dut_a (
      .clk(clk), .rst_a_n(rst_a_n), .btn_in(btn_in), .sample_tick(sample_tick),
      .btn_db(db_a), .btn_rise(rise_a), .btn_fall(fall_a), .busy(busy_a)
   );

   debounce_fsm #(.N_STABLE(1)) dut_b (
      .clk(clk), .rst_a_n(rst_a_n), .btn_in(btn_in), .sample_tick(sample_tick),
      .btn_db(db_b), .btn_rise(rise_b), .btn_fall(fall_b), .busy(busy_b)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int rise_cnt = 0;
   int fall_cnt = 0;

   // Reference model: history of synchronized samples taken on ticks; a level
   // flips once the trailing samples since the last commit all disagree with it
   // and there are at least N_STABLE of them.
   int nst[2] = '{4, 1};
   bit samp[$];
   int base[2] = '{0, 0};
   bit m_db[2] = '{1'b0, 1'b0};
   bit m_rise[2] = '{1'b0, 1'b0};
   bit m_fall[2] = '{1'b0, 1'b0};
   bit m_busy[2] = '{1'b0, 1'b0};
   bit pipe1 = 1'b0;
   bit pipe2 = 1'b0;

   typedef struct {
      bit b; bit t; bit db; bit rise; bit fall; bit busy;
   } vec_t;
   vec_t tbl[19];

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: actual %b required %b", name, $time, act, exp);
      end
   endtask

   task automatic model_edge(input bit b, input bit t);
      bit s;
      int run;
      s = pipe2;
      pipe2 = pipe1;
      pipe1 = b;
      for (int d = 0; d < 2; d++) begin
         m_rise[d] = 1'b0;
         m_fall[d] = 1'b0;
      end
      if (t) begin
         samp.push_back(s);
         for (int d = 0; d < 2; d++) begin
            run = 0;
            for (int j = samp.size() - 1; j >= base[d] && samp[j] != m_db[d]; j--) run++;
            if (run >= nst[d]) begin
               m_db[d] = ~m_db[d];
               m_rise[d] = m_db[d];
               m_fall[d] = ~m_db[d];
               m_busy[d] = 1'b0;
               base[d] = samp.size();
            end else begin
               m_busy[d] = (run > 0);
            end
         end
      end
   endtask

   task automatic step(input bit b, input bit t);
      @(negedge clk);
      btn_in = b;
      sample_tick = t;
      @(posedge clk);
      model_edge(b, t);
      #1;
      if (rise_a === 1'b1) rise_cnt++;
      if (fall_a === 1'b1) fall_cnt++;
   endtask

   task automatic cmp_all();
      check("db_a", db_a, m_db[0]);
      check("rise_a", rise_a, m_rise[0]);
      check("fall_a", fall_a, m_fall[0]);
      check("busy_a", busy_a, m_busy[0]);
      check("db_b", db_b, m_db[1]);
      check("rise_b", rise_b, m_rise[1]);
      check("fall_b", fall_b, m_fall[1]);
      check("busy_b", busy_b, m_busy[1]);
   endtask

   // Sample tick on every 10th cycle
   task automatic stepc(input bit b);
      step(b, (cyc % 10) == 9);
      cyc++;
      cmp_all();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_db_a"}, db_a, 1'b0);
      check({tag, "_rise_a"}, rise_a, 1'b0);
      check({tag, "_fall_a"}, fall_a, 1'b0);
      check({tag, "_busy_a"}, busy_a, 1'b0);
      check({tag, "_db_b"}, db_b, 1'b0);
      check({tag, "_rise_b"}, rise_b, 1'b0);
      check({tag, "_fall_b"}, fall_b, 1'b0);
      check({tag, "_busy_b"}, busy_b, 1'b0);
   endtask

   // Asynchronous reset pulse away from the clock edge; outputs must clear at once
   task automatic hard_reset();
      @(negedge clk);
      #2 rst_a_n = 1'b0;
      #1 check_zero("async_rst");
      pipe1 = 1'b0;
      pipe2 = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_db[d] = 1'b0; m_rise[d] = 1'b0; m_fall[d] = 1'b0; m_busy[d] = 1'b0;
         base[d] = samp.size();
      end
      @(posedge clk);
      #1 rst_a_n = 1'b1;
      cyc = 0;
      rise_cnt = 0;
      fall_cnt = 0;
   endtask

   initial begin
      bit b;
      bit t;
      rst_a_n = 1'b0;
      btn_in = 1'b0;
      sample_tick = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_a_n = 1'b1;
      check_zero("reset_state");

      // Table: N_STABLE=4 with the tick mostly held high
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 19; i++) begin
         step(tbl[i].b, tbl[i].t);
         check($sformatf("tbl%0d_db", i), db_a, tbl[i].db);
         check($sformatf("tbl%0d_rise", i), rise_a, tbl[i].rise);
         check($sformatf("tbl%0d_fall", i), fall_a, tbl[i].fall);
         check($sformatf("tbl%0d_busy", i), busy_a, tbl[i].busy);
      end

      // Idle low for 100 cycles
      hard_reset();
      repeat (100) stepc(1'b0);
      check("idle_no_pulse", (rise_cnt + fall_cnt) == 0, 1'b1);

      // Clean press: busy after first tick, commit on the 4th tick edge
      repeat (10) stepc(1'b1);
      check("press_busy_1st_tick", busy_a, 1'b1);
      repeat (29) stepc(1'b1);
      check("press_db_before_4th", db_a, 1'b0);
      stepc(1'b1);
      check("press_db_at_4th", db_a, 1'b1);
      check("press_rise_at_4th", rise_a, 1'b1);
      stepc(1'b1);
      check("press_rise_one_cycle", rise_a, 1'b0);
      repeat (20) stepc(1'b1);
      check("press_rise_count", rise_cnt == 1, 1'b1);
      check("press_no_fall", fall_cnt == 0, 1'b1);

      // Release, then an interrupted press that needs 4 fresh ticks
      repeat (40) stepc(1'b0);
      check("release_fall_count", fall_cnt == 1, 1'b1);
      check("release_db", db_a, 1'b0);
      rise_cnt = 0;
      repeat (30) stepc(1'b1);
      repeat (10) stepc(1'b0);
      check("abort_busy", busy_a, 1'b0);
      check("abort_db", db_a, 1'b0);
      repeat (30) stepc(1'b1);
      check("abort_db_3_more", db_a, 1'b0);
      repeat (10) stepc(1'b1);
      check("abort_db_4_more", db_a, 1'b1);
      check("abort_rise_count", rise_cnt == 1, 1'b1);

      // Glitching between ticks, stable 1 at every sampled instant
      hard_reset();
      repeat (40) begin
         b = ((cyc % 10) == 7) ? 1'b1 : cyc[0];
         stepc(b);
      end
      check("glitch_db", db_a, 1'b1);
      check("glitch_rise_count", rise_cnt == 1, 1'b1);

      // Reset in the middle of qualification with cnt=3
      hard_reset();
      repeat (33) stepc(1'b1);
      check("midq_busy", busy_a, 1'b1);
      hard_reset();
      repeat (39) stepc(1'b1);
      check("midq_db_after_3", db_a, 1'b0);
      check("midq_busy_after_3", busy_a, 1'b1);
      stepc(1'b1);
      check("midq_db_after_4", db_a, 1'b1);

      // Randomized traffic against the reference model
      b = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) hard_reset();
         if ($urandom_range(0, 3) == 0) b = ~b;
         t = (i % 700 > 600) ? 1'b1 : ($urandom_range(0, 2) == 0);
         step(b, t);
         cmp_all();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/debounce_fsm.md
DEBOUNCE_FSM -- requirements
Module: debounce_fsm

Interface
REQ-001 SHALL have parameter N_STABLE, default 4: number of consecutive agreeing sample ticks needed to accept a new level; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-003 SHALL have port rst_a_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port btn_in, input, 1 bit: raw bouncing button level, asynchronous to clk.
REQ-005 SHALL have port sample_tick, input, 1 bit: one-cycle strobe from the upstream tick counter (its match output).
REQ-006 SHALL have port btn_db, output, 1 bit: registered debounced level.
REQ-007 SHALL have port btn_rise, output, 1 bit: one-cycle pulse on an accepted 0->1 change.
REQ-008 SHALL have port btn_fall, output, 1 bit: one-cycle pulse on an accepted 1->0 change.
REQ-009 SHALL have port busy, output, 1 bit: high while a candidate change is being qualified (WAIT states).

Function
REQ-010 SHALL pass btn_in through a 2-flop synchronizer; only the second flop (btn_sync) feeds any further logic.
REQ-011 SHALL implement states S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW, plus a stability counter cnt of width $clog2(N_STABLE+1).
REQ-012 SHALL evaluate btn_sync only in cycles with sample_tick=1; with sample_tick=0, state, cnt and btn_db hold, regardless of btn_sync activity.
REQ-013 In S_LOW on a tick with btn_sync=1: if N_STABLE=1, commit high (REQ-016); otherwise go to S_WAIT_HIGH with cnt=1.
REQ-014 In S_WAIT_HIGH on a tick: if btn_sync=1, cnt increments; when the incremented value equals N_STABLE, commit high.
REQ-015 In S_WAIT_HIGH on a tick with btn_sync=0, SHALL return to S_LOW with cnt=0 and no output change.
REQ-016 Committing high SHALL be: state becomes S_HIGH, btn_db becomes 1, btn_rise is 1 for exactly that next cycle, and cnt becomes 0, all at the same clock edge.
REQ-017 S_HIGH/S_WAIT_LOW SHALL mirror REQ-013..REQ-016 with the levels inverted, producing btn_fall instead of btn_rise.
REQ-018 In S_LOW or S_HIGH, a tick with btn_sync equal to btn_db SHALL leave the state unchanged, with cnt held at 0.
REQ-019 btn_rise and btn_fall SHALL be registered, never both high, and each deasserted in the cycle after assertion, even if sample_tick is held high.
REQ-020 busy SHALL be 1 exactly when the state is S_WAIT_HIGH or S_WAIT_LOW, and registered.
REQ-021 SHALL make btn_db change exactly on the clk edge of the N_STABLE-th consecutive agreeing tick. With btn_in stable, the latency is 2 synchronizer cycles plus the cycles to that tick.
REQ-022 SHALL never exceed N_STABLE in cnt; no wrap-around SHALL be possible.

Reset
REQ-023 While rst_a_n=0, immediately and independent of clk: synchronizer flops=0, state=S_LOW, cnt=0, btn_db=0, btn_rise=0, btn_fall=0, busy=0.
REQ-024 Reset asserted mid-qualification (WAIT state) SHALL discard the candidate. After release, the block SHALL behave as from power-up; the first edge after deassertion starts normal operation.

Verification (N_STABLE=4, sample_tick every 10th cycle)
REQ-025 Reset then btn_in=0 for 100 cycles -> btn_db=0, no pulses, busy=0 throughout.
REQ-026 btn_in 0->1 held clean -> busy=1 after 1st tick; btn_db=1 and btn_rise one-cycle on the 4th tick edge; btn_fall never asserted.
REQ-027 btn_in 1 for 3 ticks, 0 at 4th tick, then 1 steady -> return to S_LOW at 4th tick with no pulse; accepted only after 4 further agreeing ticks.
REQ-028 btn_in toggling every cycle between ticks, stable 1 at each tick -> accepted after 4 ticks; intermediate glitches have no effect.
REQ-029 From btn_db=1, release btn_in -> btn_fall one-cycle and btn_db=0 on the 4th agreeing tick; with N_STABLE=1 rebuild -> commit on first tick, busy never 1.
REQ-030 rst_a_n pulsed low asynchronously in S_WAIT_HIGH with cnt=3 -> all outputs 0 immediately; held btn_in=1 afterwards requires 4 fresh ticks.
